hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard scheduler for the 5-stage branch-predicting core. It decides, every cycle, which pipeline registers hold, which get a bubble and which get flushed. Its inputs are load-use and branch-operand hazards in ID, I-/D-cache stalls and branch mispredicts. It sits beside the forwarding unit: the forwarding unit resolves ALU-result dependencies, and this block stalls the ones forwarding cannot cover (load data not yet available).

Parameters:
CNT_W, 16, width of the bubble counter and of the optional performance counters

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
ID_rs1  input  5  rs1 of instruction in ID
ID_rs2  input  5  rs2 of instruction in ID
ID_use_rs1  input  1  ID instruction reads rs1
ID_use_rs2  input  1  ID instruction reads rs2
ID_is_branch  input  1  ID instruction is a conditional branch or JALR (operands resolved in ID)
EX_mem_read  input  1  EX instruction is a load
EX_reg_write  input  1  EX instruction writes rd
EX_rd  input  5  EX destination
ME_mem_read  input  1  ME instruction is a load
ME_rd  input  5  ME destination
br_mispredict  input  1  ID branch resolved opposite to prediction (valid only when ID not stalled)
icache_stall  input  1  I-cache miss in progress
dcache_stall  input  1  D-cache miss in progress
PC_hold  output  1  PC keeps its value
IF_ID_hold  output  1  IF/ID register keeps its value
ID_EX_bubble  output  1  ID/EX register loads a NOP (control bits zeroed)
pipe_freeze  output  1  EX/ME and ME/WB registers hold
IF_ID_flush  output  1  IF/ID register loads a NOP
state_o  output  2  current FSM state (debug)

Behaviour:
- Match rule: hazard on rs1 if ID_use_rs1 && rs1!=0 && rs1==rd. Same rule for rs2.
- Combinational hazard terms:
  - load_use = EX_mem_read && match(EX_rd). Needs 1 bubble.
  - br_ex_alu = ID_is_branch && EX_reg_write && !EX_mem_read && match(EX_rd). Needs 0 bubbles (EX-to-ID forward path exists).
  - br_ex_load = ID_is_branch && EX_mem_read && match(EX_rd). Needs 2 bubbles.
  - br_me_load = ID_is_branch && ME_mem_read && match(ME_rd). Needs 1 bubble.
- FSM states:
  - RUN=0: normal issue.
  - BUBBLE=1: inserting bubbles, counter bub_cnt.
  - FREEZE=2: cache miss.
  - FLUSH=3: one-cycle redirect.
- Priority, highest first: cache stall > data hazard > mispredict.
- RUN:
  - If icache_stall || dcache_stall: go to FREEZE. Outputs this same cycle: PC_hold=IF_ID_hold=pipe_freeze=1, ID_EX_bubble=0.
  - Else if br_ex_load: go to BUBBLE with bub_cnt=1. Outputs this cycle: PC_hold=IF_ID_hold=ID_EX_bubble=1.
  - Else if load_use || br_me_load: same outputs, stay in RUN (single bubble; the next cycle the hazard term clears naturally).
  - Else if br_mispredict: go to FLUSH. IF_ID_flush=1 this cycle.
- BUBBLE:
  - PC_hold=IF_ID_hold=ID_EX_bubble=1.
  - Decrement bub_cnt. When bub_cnt==0, return to RUN.
  - A cache stall in BUBBLE goes to FREEZE with bub_cnt preserved. On exit from FREEZE, resume BUBBLE if bub_cnt!=0.
- FREEZE:
  - All holds asserted, no bubble, no flush. br_mispredict is ignored (ID is frozen).
  - Exit when both cache stalls are low: return to BUBBLE if bub_cnt!=0, else RUN. Exit-cycle outputs are decided by RUN/BUBBLE rules.
- FLUSH:
  - IF_ID_flush=0, no holds. Go to RUN next cycle.
  - Hazard evaluation is identical to RUN, since the new fetch is in IF only.
- br_mispredict is masked whenever any hold or bubble is asserted the same cycle.
- Reset (async, mid-operation included): state=RUN, bub_cnt=0, all outputs 0, state_o=0. The first cycle after reset deassertion evaluates hazards as in RUN.
- bub_cnt is CNT_W bits wide and never exceeds 2. Underflow is impossible by construction; verification asserts it.

Optional Feature:
HAZARD_PERF_CNT_EN:
- When defined, adds three saturating CNT_W-bit counters: stall_cycles (any hold), bubble_count (ID_EX_bubble cycles) and flush_count (IF_ID_flush cycles).
- Adds read ports perf_stall, perf_bubble and perf_flush (output, CNT_W each) and input perf_clr. perf_clr synchronously zeroes all three; clear wins over increment.
- Counters saturate at all-ones and reset to 0 on rst_n.
- Undefined: no counters, no ports; logic identical otherwise.

Test Plan:
- lw x5 in EX, ID add uses rs1=x5 → exactly 1 cycle PC_hold=IF_ID_hold=ID_EX_bubble=1, then RUN. With rs1=x0 → no stall.
- lw x6 in EX, ID beq reads x6 → 2 consecutive bubble cycles; state_o 0→1→0. Same with x6 in ME load → 1 bubble.
- br_ex_load then dcache_stall high for 4 cycles during BUBBLE → 4 FREEZE cycles, then remaining 1 bubble, total holds = 2+4 cycles.
- br_mispredict with no hazard → IF_ID_flush=1 for 1 cycle, state 0→3→0. br_mispredict during load_use → flush suppressed.
- icache_stall and load_use asserted together → FREEZE, no bubble. After release, load_use still present → 1 bubble.
- rst_n pulled low in BUBBLE with bub_cnt=1 → all outputs 0 immediately, state_o=0. With HAZARD_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: decides holds, bubbles and flushes for the 5-stage core.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/bubble/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             ID_is_branch,
  input  logic             EX_mem_read,
  input  logic             EX_reg_write,
  input  logic [4:0]       EX_rd,
  input  logic             ME_mem_read,
  input  logic [4:0]       ME_rd,
  input  logic             br_mispredict,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             PC_hold,
  output logic             IF_ID_hold,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic             IF_ID_flush,
`ifdef HAZARD_PERF_CNT_EN
  input  logic             perf_clr,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StBubble = 2'd1,
    StFreeze = 2'd2,
    StFlush  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

  function automatic logic src_match(input logic use_rs, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return use_rs && (rs != 5'd0) && (rs == rd);
  endfunction

  logic ex_match, me_match;
  logic load_use, br_ex_alu, br_ex_load, br_me_load, cache_stall;

  assign ex_match    = src_match(ID_use_rs1, ID_rs1, EX_rd) | src_match(ID_use_rs2, ID_rs2, EX_rd);
  assign me_match    = src_match(ID_use_rs1, ID_rs1, ME_rd) | src_match(ID_use_rs2, ID_rs2, ME_rd);
  assign load_use    = EX_mem_read & ex_match;
  assign br_ex_load  = ID_is_branch & EX_mem_read & ex_match;
  assign br_me_load  = ID_is_branch & ME_mem_read & me_match;
  assign cache_stall = icache_stall | dcache_stall;

  // ALU result reaches ID through the EX-to-ID forward path, so no stall is needed.
  assign br_ex_alu = ID_is_branch & EX_reg_write & ~EX_mem_read & ex_match;
  logic unused_br_ex_alu;
  assign unused_br_ex_alu = br_ex_alu;

  always_comb begin
    state_d      = state_q;
    bub_cnt_d    = bub_cnt_q;
    PC_hold      = 1'b0;
    IF_ID_hold   = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    IF_ID_flush  = 1'b0;

    if (cache_stall) begin
      state_d     = StFreeze;
      PC_hold     = 1'b1;
      IF_ID_hold  = 1'b1;
      pipe_freeze = 1'b1;
    end else if ((state_q == StBubble || state_q == StFreeze) && bub_cnt_q != '0) begin
      // Owed bubbles are paid out before any new hazard is looked at.
      PC_hold      = 1'b1;
      IF_ID_hold   = 1'b1;
      ID_EX_bubble = 1'b1;
      bub_cnt_d    = bub_cnt_q - CNT_W'(1);
      state_d      = (bub_cnt_q == CNT_W'(1)) ? StRun : StBubble;
    end else begin
      state_d = StRun;
      if (br_ex_load || load_use || br_me_load) begin
        PC_hold      = 1'b1;
        IF_ID_hold   = 1'b1;
        ID_EX_bubble = 1'b1;
        if (br_ex_load) begin
          bub_cnt_d = CNT_W'(1);
          state_d   = StBubble;
        end
      end else if (br_mispredict) begin
        IF_ID_flush = 1'b1;
        state_d     = StFlush;
      end
    end

    // Outputs are quiet for the whole time reset is held.
    if (!rst_n) begin
      PC_hold      = 1'b0;
      IF_ID_hold   = 1'b0;
      ID_EX_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      IF_ID_flush  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      bub_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic any_hold;
  assign any_hold = PC_hold | IF_ID_hold | pipe_freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else if (perf_clr) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      if (any_hold && perf_stall != '1)      perf_stall  <= perf_stall + CNT_W'(1);
      if (ID_EX_bubble && perf_bubble != '1) perf_bubble <= perf_bubble + CNT_W'(1);
      if (IF_ID_flush && perf_flush != '1)   perf_flush  <= perf_flush + CNT_W'(1);
    end
  end
`endif

  bub_cnt_le_two: assert property (@(posedge clk) disable iff (!rst_n)
    bub_cnt_q <= CNT_W'(2));
  bub_cnt_live_in_bubble: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StBubble) |-> (bub_cnt_q != '0));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a bubble-debt reference model.
module tb_hazard_ctrl;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] ID_rs1, ID_rs2, EX_rd, ME_rd;
  logic ID_use_rs1, ID_use_rs2, ID_is_branch, EX_mem_read, EX_reg_write, ME_mem_read;
  logic br_mispredict, icache_stall, dcache_stall;
  logic PC_hold, IF_ID_hold, ID_EX_bubble, pipe_freeze, IF_ID_flush;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic perf_clr;
  logic [CNT_W-1:0] perf_stall, perf_bubble, perf_flush;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .ID_is_branch(ID_is_branch), .EX_mem_read(EX_mem_read), .EX_reg_write(EX_reg_write),
    .EX_rd(EX_rd), .ME_mem_read(ME_mem_read), .ME_rd(ME_rd),
    .br_mispredict(br_mispredict), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .PC_hold(PC_hold), .IF_ID_hold(IF_ID_hold), .ID_EX_bubble(ID_EX_bubble),
    .pipe_freeze(pipe_freeze), .IF_ID_flush(IF_ID_flush),
`ifdef HAZARD_PERF_CNT_EN
    .perf_clr(perf_clr), .perf_stall(perf_stall), .perf_bubble(perf_bubble),
    .perf_flush(perf_flush),
`endif
    .state_o(state_o)
  );

  typedef struct packed {
    logic [4:0] rs1, rs2;
    logic       use1, use2, is_br, ex_mr, ex_rw;
    logic [4:0] ex_rd;
    logic       me_mr;
    logic [4:0] me_rd;
    logic       mis, ic, dc, clr;
  } stim_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bubbles still owed, the state code expected now, perf tallies.
  int owed = 0;
  int m_state = 0;
  int m_stall = 0, m_bub = 0, m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit hit(input logic u, input logic [4:0] rs, input logic [4:0] rd);
    return u && rs != 0 && rs == rd;
  endfunction

  task automatic drive(input stim_t s);
    ID_rs1 = s.rs1; ID_rs2 = s.rs2; ID_use_rs1 = s.use1; ID_use_rs2 = s.use2;
    ID_is_branch = s.is_br; EX_mem_read = s.ex_mr; EX_reg_write = s.ex_rw; EX_rd = s.ex_rd;
    ME_mem_read = s.me_mr; ME_rd = s.me_rd; br_mispredict = s.mis;
    icache_stall = s.ic; dcache_stall = s.dc;
`ifdef HAZARD_PERF_CNT_EN
    perf_clr = s.clr;
`endif
  endtask

  function automatic int sat_inc(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic step(input stim_t s);
    bit eh, mh, hold, bub, frz, fl;
    int need, nxt;
    @(negedge clk);
    drive(s);
    #1;
    eh = hit(s.use1, s.rs1, s.ex_rd) || hit(s.use2, s.rs2, s.ex_rd);
    mh = hit(s.use1, s.rs1, s.me_rd) || hit(s.use2, s.rs2, s.me_rd);
    need = 0;
    if (s.is_br && s.ex_mr && eh) need = 2;
    else if ((s.ex_mr && eh) || (s.is_br && s.me_mr && mh)) need = 1;
    hold = 0; bub = 0; frz = 0; fl = 0; nxt = 0;
    if (s.ic || s.dc) begin
      hold = 1; frz = 1; nxt = 2;
    end else if (owed > 0) begin
      hold = 1; bub = 1; owed--; nxt = (owed > 0) ? 1 : 0;
    end else if (need > 0) begin
      hold = 1; bub = 1; owed = need - 1; nxt = (owed > 0) ? 1 : 0;
    end else if (s.mis) begin
      fl = 1; nxt = 3;
    end
    check("outs", {27'd0, PC_hold, IF_ID_hold, ID_EX_bubble, pipe_freeze, IF_ID_flush},
          {27'd0, hold, hold, bub, frz, fl});
    check("state", {30'd0, state_o}, m_state);
`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall", {16'd0, perf_stall}, m_stall);
    check("perf_bubble", {16'd0, perf_bubble}, m_bub);
    check("perf_flush", {16'd0, perf_flush}, m_flush);
    if (s.clr) begin
      m_stall = 0; m_bub = 0; m_flush = 0;
    end else begin
      if (hold) m_stall = sat_inc(m_stall);
      if (bub)  m_bub   = sat_inc(m_bub);
      if (fl)   m_flush = sat_inc(m_flush);
    end
`endif
    m_state = nxt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_outs", {27'd0, PC_hold, IF_ID_hold, ID_EX_bubble, pipe_freeze, IF_ID_flush}, 0);
    check("rst_state", {30'd0, state_o}, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("rst_perf", {perf_stall | perf_bubble | perf_flush}, 0);
`endif
    owed = 0; m_state = 0; m_stall = 0; m_bub = 0; m_flush = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1   = 5'($urandom_range(0, 3));
    s.rs2   = 5'($urandom_range(0, 3));
    s.use1  = 1'($urandom_range(0, 1));
    s.use2  = 1'($urandom_range(0, 1));
    s.is_br = ($urandom_range(0, 2) == 0);
    s.ex_mr = ($urandom_range(0, 2) == 0);
    s.ex_rw = 1'($urandom_range(0, 1));
    s.ex_rd = 5'($urandom_range(0, 3));
    s.me_mr = ($urandom_range(0, 2) == 0);
    s.me_rd = 5'($urandom_range(0, 3));
    s.mis   = ($urandom_range(0, 3) == 0);
    s.ic    = ($urandom_range(0, 9) == 0);
    s.dc    = ($urandom_range(0, 9) == 0);
    s.clr   = ($urandom_range(0, 49) == 0);
    return s;
  endfunction

  stim_t z, s;

  initial begin
    z = '0;
    drive(z);
    do_reset();

    // Load-use on rs1, then rs1=x0 which must not stall.
    s = z; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 5; s.use1 = 1; s.rs1 = 5;
    step(s); step(z);
    s.rs1 = 0; step(s); step(z);

    // Branch on EX load: two bubbles; then branch on ME load: one.
    s = z; s.is_br = 1; s.use2 = 1; s.rs2 = 6; s.ex_mr = 1; s.ex_rw = 1; s.ex_rd = 6;
    step(s); step(s); step(z);
    s = z; s.is_br = 1; s.use2 = 1; s.rs2 = 6; s.me_mr = 1; s.me_rd = 6;
    step(s); step(z);

    // Branch on EX load with a 4-cycle D-cache miss during the bubble.
    s = z; s.is_br = 1; s.use1 = 1; s.rs1 = 7; s.ex_mr = 1; s.ex_rd = 7;
    step(s);
    s = z; s.dc = 1;
    repeat (4) step(s);
    step(z); step(z);

    // Mispredict alone, then mispredict masked by load-use.
    s = z; s.mis = 1; step(s); step(z);
    s.ex_mr = 1; s.ex_rd = 3; s.use1 = 1; s.rs1 = 3; step(s); step(z);

    // I-cache miss together with load-use, then load-use alone.
    s = z; s.ic = 1; s.ex_mr = 1; s.ex_rd = 2; s.use2 = 1; s.rs2 = 2;
    step(s); step(s);
    s.ic = 0; step(s); step(z);

    // Async reset while a bubble is still owed.
    s = z; s.is_br = 1; s.use1 = 1; s.rs1 = 4; s.ex_mr = 1; s.ex_rd = 4;
    step(s);
    do_reset();
    step(z);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(rand_stim());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
